// File: rtl/prio_irq_ctrl_pkg.sv
// Shared FSM encoding and priority-mode constants for the interrupt controller.
package prio_irq_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_irq_ctrl_select.sv
// Combinational priority pick: rotate so the highest-priority line sits at the top,
// search for the highest set bit, then rotate the index back.
module prio_select
    import prio_irq_ctrl_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   cand,
    input  logic [IDW-1:0] rr_ptr,
    input  logic           mode,
    output logic [IDW-1:0] winner,
    output logic           any
);

    logic [IDW-1:0] ptr_c;
    logic [N-1:0]   rot_c;
    int unsigned    sh_c;
    int unsigned    hi_c;
    int unsigned    idx_c;

    // Fixed mode behaves as rotating priority pinned at the top line.
    assign ptr_c = (mode == MODE_RR) ? rr_ptr : IDW'(N - 1);

    always_comb begin
        sh_c  = 32'(ptr_c) + 32'd1;
        rot_c = N'({cand, cand} >> sh_c);
        hi_c  = 32'd0;
        for (int unsigned j = 0; j < N; j++) begin
            if (rot_c[j]) hi_c = j;
        end
        idx_c = hi_c + sh_c;
        if (idx_c >= N) idx_c = idx_c - N;
    end

    assign winner = IDW'(idx_c);
    assign any    = |cand;

endmodule

// File: rtl/prio_irq_ctrl.sv
// Edge-capturing interrupt controller: pending flags, mask, fixed/rotating priority
// winner presented to the control unit through a valid/ack handshake.
module prio_irq_ctrl
    import prio_irq_ctrl_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned IDW         = $clog2(N),
    parameter bit          ROUND_ROBIN = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic           ack,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    output logic [N-1:0]   pending
);

    localparam logic           MODE     = ROUND_ROBIN ? MODE_RR : MODE_FIXED;
    localparam logic [IDW-1:0] PTR_INIT = IDW'(N - 1);
    localparam logic [N-1:0]   ONE      = N'(1);

    state_t         state_q, state_d;
    logic [N-1:0]   req_q;
    logic [N-1:0]   rise_c;
    logic [N-1:0]   clear_c;
    logic [N-1:0]   cand_c;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] winner_c;
    logic           any_c;
    logic           irq_valid_d;
    logic [IDW-1:0] irq_id_d;

    assign rise_c = req & ~req_q;
    assign cand_c = pending & ~mask;

    prio_select #(
        .N   (N),
        .IDW (IDW)
    ) u_select (
        .cand   (cand_c),
        .rr_ptr (rr_ptr_q),
        .mode   (MODE),
        .winner (winner_c),
        .any    (any_c)
    );

    // A new edge on the bit being cleared wins, so the interrupt is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clear_c) | rise_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            rr_ptr_q  <= PTR_INIT;
        end else begin
            state_q   <= state_d;
            irq_valid <= irq_valid_d;
            irq_id    <= irq_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Once presented, the ID is held until ack regardless of enable, mask or new requests.
    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid;
        irq_id_d    = irq_id;
        rr_ptr_d    = rr_ptr_q;
        clear_c     = '0;
        case (state_q)
            IDLE: begin
                if (enable && any_c) begin
                    state_d     = PRESENT;
                    irq_valid_d = 1'b1;
                    irq_id_d    = winner_c;
                    if (MODE == MODE_RR) begin
                        rr_ptr_d = (winner_c == '0) ? PTR_INIT : winner_c - IDW'(1);
                    end
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d     = IDLE;
                    irq_valid_d = 1'b0;
                    clear_c     = ONE << irq_id;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Directed + random bench for prio_irq_ctrl, fixed and round-robin instances side by side.
module tb_prio_irq_ctrl;

    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NL-1:0] req;
    logic [NL-1:0] mask;
    logic          ack_f, ack_r;
    logic          fix_valid, rr_valid;
    logic [2:0]    fix_id, rr_id;
    logic [NL-1:0] fix_pending, rr_pending;

    int vectors = 0;
    int miscompares = 0;

    // Reference state per instance: 0 = fixed, 1 = round-robin
    bit m_pend [2][NL];
    bit m_reqq [2][NL];
    bit m_valid[2];
    int m_id   [2];
    int m_ptr  [2];

    always #5 clk = ~clk;

    prio_irq_ctrl #(.N(NL), .ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .mask(mask), .ack(ack_f),
        .irq_valid(fix_valid), .irq_id(fix_id), .pending(fix_pending)
    );

    prio_irq_ctrl #(.N(NL), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .mask(mask), .ack(ack_r),
        .irq_valid(rr_valid), .irq_id(rr_id), .pending(rr_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NL; i++) begin
                m_pend[d][i] = 1'b0;
                m_reqq[d][i] = 1'b0;
            end
            m_valid[d] = 1'b0;
            m_id[d]    = 0;
            m_ptr[d]   = NL - 1;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit a;
            int clr, win, start, idx;
            a     = (d == 1) ? ack_r : ack_f;
            clr   = (m_valid[d] && a) ? m_id[d] : -1;
            win   = -1;
            start = (d == 1) ? m_ptr[d] : NL - 1;
            if (!m_valid[d] && enable) begin
                for (int k = 0; k < NL; k++) begin
                    idx = (start - k + NL) % NL;
                    if (win < 0 && m_pend[d][idx] && !mask[idx]) win = idx;
                end
            end
            if (m_valid[d]) begin
                if (a) m_valid[d] = 1'b0;
            end else if (win >= 0) begin
                m_valid[d] = 1'b1;
                m_id[d]    = win;
                if (d == 1) m_ptr[d] = (win + NL - 1) % NL;
            end
            for (int i = 0; i < NL; i++) begin
                m_pend[d][i] = (m_pend[d][i] && i != clr) || (req[i] && !m_reqq[d][i]);
                m_reqq[d][i] = req[i];
            end
        end
    endtask

    task automatic check_all();
        logic [NL-1:0] p;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NL; i++) p[i] = m_pend[d][i];
            chk(d ? "rr_valid" : "fix_valid", d ? rr_valid : fix_valid, 32'(m_valid[d]));
            chk(d ? "rr_pending" : "fix_pending", d ? rr_pending : fix_pending, 32'(p));
            if (m_valid[d]) chk(d ? "rr_id" : "fix_id", d ? rr_id : fix_id, 32'(m_id[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; req = '0; mask = '0; ack_f = 1'b0; ack_r = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int pres;
        logic prev;
        int exp_rr[6] = '{7, 3, 1, 7, 3, 1};
        int waited;

        reset = 1'b1; enable = 1'b1; req = '0; mask = '0; ack_f = 1'b0; ack_r = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_id", 32'(fix_id), 32'd0);
        do_reset();

        // Simultaneous pulses on 2 and 5: highest index first, then the other.
        req = 8'h24; tick(); req = '0; tick();
        chk("t1_first_valid", 32'(fix_valid), 32'd1);
        chk("t1_first_id", 32'(fix_id), 32'd5);
        ack_f = 1'b1; ack_r = 1'b1; tick();
        chk("t1_gap", 32'(fix_valid), 32'd0);
        ack_f = 1'b0; ack_r = 1'b0; tick();
        chk("t1_second_id", 32'(fix_id), 32'd2);
        ack_f = 1'b1; ack_r = 1'b1; tick();
        ack_f = 1'b0; ack_r = 1'b0; tick();
        chk("t1_pending_empty", 32'(fix_pending), 32'd0);

        // Held level presents once; masked line stays pending until unmasked.
        req = 8'h40; pres = 0; prev = fix_valid;
        for (int i = 0; i < 20; i++) begin
            ack_f = fix_valid; ack_r = rr_valid;
            tick();
            if (fix_valid && !prev) pres++;
            prev = fix_valid;
        end
        chk("t2_hold_once", 32'(pres), 32'd1);
        req = '0; ack_f = 1'b0; ack_r = 1'b0; tick();
        mask = 8'h40; req = 8'h40; tick(); req = '0;
        repeat (3) tick();
        chk("t2_masked_pending", 32'(fix_pending[6]), 32'd1);
        chk("t2_masked_novalid", 32'(fix_valid), 32'd0);
        mask = '0; tick();
        chk("t2_unmask_valid", 32'(fix_valid), 32'd1);
        chk("t2_unmask_id", 32'(fix_id), 32'd6);
        ack_f = 1'b1; ack_r = 1'b1; tick(); ack_f = 1'b0; ack_r = 1'b0;

        // Round-robin rotation with re-pulsed lines.
        do_reset();
        req = 8'h8A; tick(); req = '0;
        for (int g = 0; g < 6; g++) begin
            waited = 0;
            while (!rr_valid && waited < 8) begin tick(); waited++; end
            if (!rr_valid) chk("t3_timeout", 32'(rr_valid), 32'd1);
            chk("t3_rr_order", 32'(rr_id), 32'(exp_rr[g]));
            ack_r = 1'b1; tick(); ack_r = 1'b0;
            req = 8'(1) << rr_id; tick(); req = '0;
        end

        // Presented ID stays fixed while enable drops and a higher line arrives.
        do_reset();
        req = 8'h02; tick(); req = '0; tick();
        chk("t4_first_id", 32'(fix_id), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin req = 8'h80; enable = 1'b0; end
            if (i == 3) req = '0;
            tick();
            chk("t4_hold_valid", 32'(fix_valid), 32'd1);
            chk("t4_hold_id", 32'(fix_id), 32'd1);
        end
        enable = 1'b1; ack_f = 1'b1; ack_r = 1'b1; tick();
        ack_f = 1'b0; ack_r = 1'b0; tick();
        chk("t4_next_id", 32'(fix_id), 32'd7);
        ack_f = 1'b1; ack_r = 1'b1; tick(); ack_f = 1'b0; ack_r = 1'b0; tick();

        // New edge on the bit being acknowledged keeps it pending.
        do_reset();
        req = 8'h10; tick(); req = '0; tick();
        chk("t5_id", 32'(fix_id), 32'd4);
        ack_f = 1'b1; ack_r = 1'b1; req = 8'h10; tick();
        chk("t5_pending4", 32'(fix_pending[4]), 32'd1);
        chk("t5_gap", 32'(fix_valid), 32'd0);
        ack_f = 1'b0; ack_r = 1'b0; req = '0; tick();
        chk("t5_re_valid", 32'(fix_valid), 32'd1);
        chk("t5_re_id", 32'(fix_id), 32'd4);
        ack_f = 1'b1; ack_r = 1'b1; tick(); ack_f = 1'b0; ack_r = 1'b0; tick();

        // Asynchronous reset while presenting.
        do_reset();
        req = 8'hA5; tick(); req = '0; tick();
        chk("t6_pending", 32'(fix_pending), 32'hA5);
        chk("t6_valid", 32'(fix_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_async_valid", 32'(fix_valid), 32'd0);
        chk("t6_async_pending", 32'(fix_pending), 32'd0);
        chk("t6_async_rr_valid", 32'(rr_valid), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_quiet", 32'(fix_valid), 32'd0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            req    = NL'($urandom);
            mask   = NL'($urandom & $urandom);
            enable = ($urandom % 4) != 0;
            ack_f  = 1'($urandom);
            ack_r  = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
